// File: rtl/matrix_op_sequencer.sv
// Matrix calculator control FSM: loads operands A/B into the register
// file, issues one ALU request, then reports result or error status.
module matrix_op_sequencer #(
  parameter  int ELEMS   = 4,
  parameter  int DW      = 8,
  parameter  int TIMEOUT = 16,
  localparam int IW      = $clog2(ELEMS)
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          clr,
  input  logic          num_valid,
  input  logic [DW-1:0] num_data,
  input  logic          is_op,
  input  logic [2:0]    op_code,
  input  logic          is_enter,
  input  logic          alu_done,
  output logic          wr_en,
  output logic          wr_sel,
  output logic [IW-1:0] wr_idx,
  output logic [DW-1:0] wr_data,
  output logic          alu_start,
  output logic [2:0]    alu_op,
  output logic          busy,
  output logic          result_valid,
  output logic          error,
  output logic [2:0]    state_out
);

  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    LOAD_A     = 3'd1,
    WAIT_OP    = 3'd2,
    LOAD_B     = 3'd3,
    WAIT_ENTER = 3'd4,
    EXEC       = 3'd5,
    RESULT     = 3'd6,
    ERROR      = 3'd7
  } state_t;

  state_t        state, nstate;
  logic [IW-1:0] idx, nidx;
  logic [CW-1:0] cnt, ncnt;
  logic [2:0]    nop;
  logic          we, wsel, start;
  logic [IW-1:0] widx;
  logic          last;

  assign last = (idx == IW'(ELEMS - 1));

  always_comb begin
    nstate = state;
    nidx   = idx;
    ncnt   = cnt;
    nop    = alu_op;
    we     = 1'b0;
    wsel   = 1'b0;
    widx   = idx;
    start  = 1'b0;
    unique case (state)
      IDLE, RESULT: begin
        if (num_valid) begin
          we     = 1'b1;
          widx   = '0;
          nidx   = IW'(1);
          nstate = LOAD_A;
        end else if (is_enter && state == RESULT) begin
          nstate = IDLE;
        end
      end
      LOAD_A, LOAD_B: begin
        wsel = (state == LOAD_B);
        if (num_valid) begin
          we   = 1'b1;
          nidx = idx + 1'b1;
          if (last) begin
            nidx   = '0;
            nstate = (state == LOAD_A) ? WAIT_OP : WAIT_ENTER;
          end
        end
      end
      WAIT_OP: begin
        if (is_op) begin
          if (op_code == 3'b001 || op_code == 3'b010) begin
            nop    = op_code;
            nstate = LOAD_B;
          end else begin
            nstate = ERROR;
          end
        end
      end
      WAIT_ENTER: begin
        if (is_enter) begin
          start  = 1'b1;
          ncnt   = '0;
          nstate = EXEC;
        end
      end
      EXEC: begin
        // alu_done takes precedence over the final timeout cycle
        if (alu_done) nstate = RESULT;
        else if (cnt == CW'(TIMEOUT - 1)) nstate = ERROR;
        else ncnt = cnt + 1'b1;
      end
      ERROR: ;
      default: nstate = IDLE;
    endcase
    if (clr) begin
      nstate = IDLE;
      nidx   = '0;
      nop    = 3'b000;
      ncnt   = '0;
      we     = 1'b0;
      start  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state        <= IDLE;
      idx          <= '0;
      cnt          <= '0;
      alu_op       <= 3'b000;
      wr_en        <= 1'b0;
      wr_sel       <= 1'b0;
      wr_idx       <= '0;
      wr_data      <= '0;
      alu_start    <= 1'b0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      error        <= 1'b0;
      state_out    <= 3'd0;
    end else begin
      state        <= nstate;
      idx          <= nidx;
      cnt          <= ncnt;
      alu_op       <= nop;
      wr_en        <= we;
      alu_start    <= start;
      busy         <= (nstate == EXEC);
      result_valid <= (nstate == RESULT);
      error        <= (nstate == ERROR);
      state_out    <= nstate;
      if (we) begin
        wr_sel  <= wsel;
        wr_idx  <= widx;
        wr_data <= num_data;
      end
    end
  end

endmodule

// File: tb/tb_matrix_op_sequencer.sv
// Bench for matrix_op_sequencer: directed scenarios plus random strobes,
// every cycle checked against a phase-level reference model.
module tb_matrix_op_sequencer;

  localparam int E = 4;
  localparam int T = 16;

  localparam int P_IDLE = 0, P_LA = 1, P_WOP = 2, P_LB = 3;
  localparam int P_WEN = 4, P_EX = 5, P_RES = 6, P_ERR = 7;

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic       clr = 1'b0;
  logic       num_valid = 1'b0;
  logic [7:0] num_data = 8'd0;
  logic       is_op = 1'b0;
  logic [2:0] op_code = 3'd0;
  logic       is_enter = 1'b0;
  logic       alu_done = 1'b0;
  logic       wr_en, wr_sel, alu_start, busy, result_valid, error;
  logic [1:0] wr_idx;
  logic [7:0] wr_data;
  logic [2:0] alu_op, state_out;

  int n_assert = 0;
  int n_fail = 0;

  int         ph = P_IDLE;
  int         n_in = 0;
  int         waited = 0;
  logic [2:0] m_op = 3'd0;
  logic       m_we = 1'b0;
  logic       m_sel = 1'b0;
  int         m_idx = 0;
  logic [7:0] m_data = 8'd0;
  logic       m_start = 1'b0;

  logic       r_c, r_nv, r_iop, r_ie, r_ad;
  logic [7:0] r_nd;
  logic [2:0] r_oc;

  matrix_op_sequencer #(.ELEMS(E), .DW(8), .TIMEOUT(T)) dut (
    .clk(clk), .nrst(nrst), .clr(clr),
    .num_valid(num_valid), .num_data(num_data),
    .is_op(is_op), .op_code(op_code),
    .is_enter(is_enter), .alu_done(alu_done),
    .wr_en(wr_en), .wr_sel(wr_sel),
    .wr_idx(wr_idx), .wr_data(wr_data),
    .alu_start(alu_start), .alu_op(alu_op),
    .busy(busy), .result_valid(result_valid),
    .error(error), .state_out(state_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    ph = P_IDLE; n_in = 0; waited = 0; m_op = 3'd0;
    m_we = 1'b0; m_start = 1'b0;
  endtask

  task automatic model_write(input logic sel, input int i,
                             input logic [7:0] d);
    m_we = 1'b1; m_sel = sel; m_idx = i; m_data = d;
  endtask

  task automatic model(input logic c, input logic nv,
                       input logic [7:0] nd, input logic iop,
                       input logic [2:0] oc, input logic ie,
                       input logic ad);
    m_we = 1'b0;
    m_start = 1'b0;
    if (c) begin
      ph = P_IDLE; n_in = 0; m_op = 3'd0;
    end else begin
      case (ph)
        P_IDLE, P_RES: begin
          if (nv) begin
            model_write(1'b0, 0, nd); n_in = 1; ph = P_LA;
          end else if (ie && ph == P_RES) ph = P_IDLE;
        end
        P_LA, P_LB: begin
          if (nv) begin
            model_write(ph == P_LB, n_in, nd);
            n_in++;
            if (n_in == E) begin
              n_in = 0;
              ph = (ph == P_LA) ? P_WOP : P_WEN;
            end
          end
        end
        P_WOP: begin
          if (iop) begin
            if (oc == 3'd1 || oc == 3'd2) begin
              m_op = oc; ph = P_LB;
            end else ph = P_ERR;
          end
        end
        P_WEN: begin
          if (ie) begin
            ph = P_EX; waited = 0; m_start = 1'b1;
          end
        end
        P_EX: begin
          waited++;
          if (ad) ph = P_RES;
          else if (waited == T) ph = P_ERR;
        end
        default: ;
      endcase
    end
  endtask

  task automatic check_all();
    chk("wr_en", wr_en, m_we);
    if (m_we) begin
      chk("wr_sel", wr_sel, m_sel);
      chk("wr_idx", wr_idx, m_idx);
      chk("wr_data", wr_data, m_data);
    end
    chk("alu_start", alu_start, m_start);
    chk("alu_op", alu_op, m_op);
    chk("busy", busy, ph == P_EX);
    chk("result_valid", result_valid, ph == P_RES);
    chk("error", error, ph == P_ERR);
    chk("state_out", state_out, ph);
  endtask

  task automatic step(input logic c, input logic nv,
                      input logic [7:0] nd, input logic iop,
                      input logic [2:0] oc, input logic ie,
                      input logic ad);
    clr = c; num_valid = nv; num_data = nd;
    is_op = iop; op_code = oc; is_enter = ie; alu_done = ad;
    @(posedge clk);
    model(c, nv, nd, iop, oc, ie, ad);
    #1;
    check_all();
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(0, 0, 8'd0, 0, 3'd0, 0, 0);
  endtask

  task automatic num(input logic [7:0] d);
    step(0, 1, d, 0, 3'd0, 0, 0);
  endtask

  task automatic opc(input logic [2:0] c);
    step(0, 0, 8'd0, 1, c, 0, 0);
  endtask

  task automatic ent();
    step(0, 0, 8'd0, 0, 3'd0, 1, 0);
  endtask

  task automatic do_clr();
    step(1, 0, 8'd0, 0, 3'd0, 0, 0);
  endtask

  task automatic to_exec(input logic [7:0] base);
    for (int i = 0; i < E; i++) num(base + 8'(i));
    opc(3'd2);
    for (int i = 0; i < E; i++) num(base + 8'(i + 8));
    ent();
  endtask

  initial begin
    #2;
    model_reset();
    chk("reset_state", state_out, 0);
    chk("reset_wr_en", wr_en, 0);
    chk("reset_wr_data", wr_data, 0);
    check_all();
    @(posedge clk); #1;
    nrst = 1'b1;
    idle(2);

    // nominal add with ignored strobes sprinkled in
    num(8'd1);
    num(8'd2);
    opc(3'd1);
    num(8'd3);
    num(8'd4);
    num(8'd99);
    ent();
    opc(3'd1);
    num(8'd5); num(8'd6); num(8'd7); num(8'd8);
    num(8'd77);
    opc(3'd2);
    ent();
    step(0, 0, 8'd0, 0, 3'd0, 0, 0);
    step(0, 0, 8'd0, 0, 3'd0, 0, 0);
    step(0, 0, 8'd0, 0, 3'd0, 0, 1);
    chk("nominal_result", state_out, 6);
    ent();
    chk("back_idle", state_out, 0);
    step(0, 0, 8'd0, 0, 3'd0, 0, 1);

    // illegal opcode, ERROR sticks until clr
    for (int i = 0; i < E; i++) num(8'(i + 20));
    opc(3'd3);
    chk("illegal_err", error, 1);
    num(8'd1); opc(3'd1); ent();
    step(0, 0, 8'd0, 0, 3'd0, 0, 1);
    do_clr();
    chk("clr_err", error, 0);

    // timeout: 16 busy cycles then ERROR
    to_exec(8'd30);
    idle(T);
    chk("timeout_err", error, 1);
    do_clr();

    // done on the final cycle wins
    to_exec(8'd40);
    idle(T - 1);
    step(0, 0, 8'd0, 0, 3'd0, 0, 1);
    chk("late_done", result_valid, 1);

    // chained calculation from RESULT
    step(0, 1, 8'd9, 0, 3'd0, 1, 0);
    chk("chain_data", wr_data, 9);
    chk("chain_state", state_out, 1);
    do_clr();

    // clr after two B writes
    for (int i = 0; i < E; i++) num(8'd50);
    opc(3'd1);
    num(8'd51); num(8'd52);
    do_clr();
    num(8'd60);
    chk("post_clr_idx", wr_idx, 0);
    do_clr();

    // async reset during EXEC
    to_exec(8'd70);
    idle(2);
    #2;
    nrst = 1'b0;
    #1;
    model_reset();
    chk("async_busy", busy, 0);
    check_all();
    @(posedge clk); #1;
    check_all();
    nrst = 1'b1;
    idle(4);

    // random strobes
    for (int i = 0; i < 600; i++) begin
      r_c  = ($urandom_range(0, 39) == 0);
      r_nv = ($urandom_range(0, 2) == 0);
      r_nd = 8'($urandom);
      r_iop = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 3) != 0) r_oc = 3'($urandom_range(1, 2));
      else r_oc = 3'($urandom_range(0, 7));
      r_ie = ($urandom_range(0, 3) == 0);
      r_ad = ($urandom_range(0, 6) == 0);
      step(r_c, r_nv, r_nd, r_iop, r_oc, r_ie, r_ad);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
